// File: rtl/prim_ram_2p_pkg.sv
// Shared types for the two-port byte-masked RAM primitive.
package prim_ram_2p_pkg;

    typedef enum logic {
        RdwReadFirst  = 1'b0,
        RdwWriteFirst = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        InitRun  = 1'b0,
        InitDone = 1'b1
    } init_state_e;

endpackage

// File: rtl/prim_xilinx_ram_2p_be_if.sv
// One RAM access port: request/grant, write data with byte mask, read response.
interface prim_xilinx_ram_2p_be_if
    import prim_ram_2p_pkg::*;
#(
    parameter int Width = 32,
    parameter int Aw    = 7,
    parameter int Nb    = 4
);
    logic             req;
    logic             gnt;
    logic             write;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] wdata;
    logic [Nb-1:0]    wmask;
    logic             rvalid;
    logic [Width-1:0] rdata;
    logic             err;

    modport master (
        output req, write, addr, wdata, wmask,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, write, addr, wdata, wmask,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/prim_ram_2p_outpipe.sv
// Optional second read-response stage; rdata only loads on a valid response.
module prim_ram_2p_outpipe #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rvalid_i,
    input  logic [Width-1:0] rdata_i,
    input  logic             err_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             err_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= rvalid_i;
            err_o    <= err_i;
            if (rvalid_i) begin
                rdata_o <= rdata_i;
            end
        end
    end

endmodule

// File: rtl/prim_xilinx_ram_2p_be.sv
// Single-clock two-port RAM with byte write masks, selectable read-during-write
// behaviour, optional output register and a post-reset zero-fill sequence.
//
// state   | meaning
// StInit  | clearing storage[init_cnt_q], requests not granted
// StReady | storage valid, both ports granted
module prim_xilinx_ram_2p_be
    import prim_ram_2p_pkg::*;
#(
    parameter int Width   = 32,
    parameter int Depth   = 128,
    parameter int ByteW   = 8,
    parameter int OutReg  = 0,
    parameter int RdwMode = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    prim_xilinx_ram_2p_be_if.slave  a_if,
    prim_xilinx_ram_2p_be_if.slave  b_if,
    output logic                    init_done_o,
    output logic                    collision_o
);

    localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int Nb = Width / ByteW;
    localparam bit Pow2Depth = (Depth == (1 << Aw));
    localparam bit WriteFirst = (RdwMode == int'(RdwWriteFirst));
    localparam logic [0:0] StInit  = 1'(InitRun);
    localparam logic [0:0] StReady = 1'(InitDone);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    if (Width % ByteW != 0) begin : g_width_check
        $fatal(1, "prim_xilinx_ram_2p_be: Width must be a multiple of ByteW");
    end

    function automatic logic [Width-1:0] merge_bytes(
        input logic [Width-1:0] base,
        input logic [Width-1:0] upd,
        input logic [Nb-1:0]    mask
    );
        logic [Width-1:0] res;
        res = base;
        for (int i = 0; i < Nb; i++) begin
            if (mask[i]) res[i*ByteW +: ByteW] = upd[i*ByteW +: ByteW];
        end
        return res;
    endfunction

    logic [Width-1:0] mem [Depth];

    logic [0:0]       state_q;
    logic [Aw-1:0]    init_cnt_q;
    logic             ready;

    logic             a_acc, b_acc;
    logic             a_in_range, b_in_range;
    logic             a_wr, b_wr;
    logic             same_addr;
    logic [Width-1:0] a_old, b_old;
    logic [Width-1:0] a_after_b, a_final, b_own, b_final;
    logic [Width-1:0] a_ret, b_ret;

    logic             a_rvalid_q, b_rvalid_q;
    logic             a_err_q, b_err_q;
    logic [Width-1:0] a_rdata_q, b_rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else if (state_q == StInit) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == LastAddr) state_q <= StReady;
        end
    end

    assign ready       = (state_q == StReady);
    assign init_done_o = ready;
    assign a_if.gnt    = ready;
    assign b_if.gnt    = ready;

    // Addresses past the end only exist when Depth is not a power of two.
    if (Pow2Depth) begin : g_range_full
        assign a_in_range = 1'b1;
        assign b_in_range = 1'b1;
    end else begin : g_range_check
        assign a_in_range = (a_if.addr < Aw'(Depth));
        assign b_in_range = (b_if.addr < Aw'(Depth));
    end

    assign a_acc     = a_if.req & ready;
    assign b_acc     = b_if.req & ready;
    assign a_wr      = a_acc & a_if.write & a_in_range;
    assign b_wr      = b_acc & b_if.write & b_in_range;
    assign same_addr = (a_if.addr == b_if.addr);

    assign a_old = a_in_range ? mem[a_if.addr] : '0;
    assign b_old = b_in_range ? mem[b_if.addr] : '0;

    // Write-first returns the word as stored after both ports' lanes land (A wins overlaps).
    assign a_after_b = (same_addr && b_wr) ? merge_bytes(a_old, b_if.wdata, b_if.wmask) : a_old;
    assign a_final   = merge_bytes(a_after_b, a_if.wdata, a_if.wmask);
    assign b_own     = merge_bytes(b_old, b_if.wdata, b_if.wmask);
    assign b_final   = (same_addr && a_wr) ? merge_bytes(b_own, a_if.wdata, a_if.wmask) : b_own;

    assign a_ret = (WriteFirst && a_wr) ? a_final : a_old;
    assign b_ret = (WriteFirst && b_wr) ? b_final : b_old;

    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem[init_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < Nb; i++) begin
                if (a_wr && a_if.wmask[i]) begin
                    mem[a_if.addr][i*ByteW +: ByteW] <= a_if.wdata[i*ByteW +: ByteW];
                end
                if (b_wr && b_if.wmask[i] && !(same_addr && a_wr && a_if.wmask[i])) begin
                    mem[b_if.addr][i*ByteW +: ByteW] <= b_if.wdata[i*ByteW +: ByteW];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            collision_o <= 1'b0;
        end else begin
            a_rvalid_q  <= a_acc;
            b_rvalid_q  <= b_acc;
            a_err_q     <= a_acc & ~a_in_range;
            b_err_q     <= b_acc & ~b_in_range;
            collision_o <= a_acc & b_acc & same_addr & (a_if.write | b_if.write);
            if (a_acc) a_rdata_q <= a_ret;
            if (b_acc) b_rdata_q <= b_ret;
        end
    end

    if (OutReg != 0) begin : g_outreg
        prim_ram_2p_outpipe #(.Width(Width)) u_outpipe_a (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rvalid_i (a_rvalid_q),
            .rdata_i  (a_rdata_q),
            .err_i    (a_err_q),
            .rvalid_o (a_if.rvalid),
            .rdata_o  (a_if.rdata),
            .err_o    (a_if.err)
        );
        prim_ram_2p_outpipe #(.Width(Width)) u_outpipe_b (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rvalid_i (b_rvalid_q),
            .rdata_i  (b_rdata_q),
            .err_i    (b_err_q),
            .rvalid_o (b_if.rvalid),
            .rdata_o  (b_if.rdata),
            .err_o    (b_if.err)
        );
    end else begin : g_no_outreg
        assign a_if.rvalid = a_rvalid_q;
        assign a_if.rdata  = a_rdata_q;
        assign a_if.err    = a_err_q;
        assign b_if.rvalid = b_rvalid_q;
        assign b_if.rdata  = b_rdata_q;
        assign b_if.err    = b_err_q;
    end

endmodule
